hmcad_sample_packer: RTL and testbench

- Downstream consumer of the ADC data-regeneration stage.
- Takes the left-justified 16-bit sample vector and its ready qualifier on DivClk, extracts 12-bit samples and packs two samples per 32-bit word.
- Buffers words in an internal show-ahead FIFO and presents them on a valid/ready stream to the Nios-side capture/DMA logic.
- Capture is run by a start/abort/length control interface with done, busy and overflow status.

---
 rtl/hmcad_sample_packer.sv | 164 ++++++++++++++++
 tb/tb_hmcad_sample_packer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hmcad_sample_packer.sv
// Packs 12-bit ADC samples two per 32-bit word into a show-ahead FIFO under start/abort/length control.
// Optional ramp test pattern (TestMode input) is built when HMCAD_PACKER_TESTPAT_EN is defined.
module hmcad_sample_packer #(
  parameter int ADDR_W   = 9,
  parameter bit SIGN_EXT = 1'b0
) (
  input  logic              DivClk,
  input  logic              Reset,
  input  logic [15:0]       DataVector,
  input  logic              DataReady,
  input  logic              Start,
  input  logic              Abort,
  input  logic [15:0]       CaptureLen,
`ifdef HMCAD_PACKER_TESTPAT_EN
  input  logic              TestMode,
`endif
  output logic [31:0]       OutData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Busy,
  output logic              Done,
  output logic              Overflow,
  output logic [ADDR_W:0]   Level
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t            state;
  logic [15:0]       lenLatched;
  logic [15:0]       wordCnt;
  logic              halfFlag;
  logic [11:0]       s0Hold;
  logic [31:0]       wordP0;
  logic              vldP0;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W:0]   level;
  logic [11:0]       sample;
  logic              startAcc;
  logic              flush;
  logic              accept;
  logic              full;
  logic              push;
  logic              pop;
  logic              wrEn;
  logic              unusedLsbs;

  function automatic logic [15:0] extendSample(input logic [11:0] s);
    logic signed [11:0] sSigned;
    logic signed [15:0] sWide;
    sSigned = signed'(s);
    sWide   = sSigned;
    return SIGN_EXT ? $unsigned(sWide) : {4'h0, s};
  endfunction

  assign unusedLsbs = ^DataVector[3:0];

`ifdef HMCAD_PACKER_TESTPAT_EN
  logic [11:0] rampCnt;
  assign sample = TestMode ? rampCnt : DataVector[15:4];
`else
  assign sample = DataVector[15:4];
`endif

  // Sample stops being accepted once the last word is formed, until DONE is entered.
  assign startAcc = (state == IDLE) && Start && !Abort;
  assign flush    = startAcc || Abort;
  assign accept   = (state == CAPTURE) && DataReady && !Abort && (wordCnt != lenLatched);
  assign full     = (level == (ADDR_W + 1)'(DEPTH));
  assign OutValid = (level != '0);
  assign pop      = OutValid && OutReady && !flush;
  assign push     = vldP0 && !flush;
  assign wrEn     = push && (!full || pop);
  assign OutData  = OutValid ? mem[rdPtr] : '0;
  assign Level    = level;

  always_ff @(posedge DivClk) begin
    if (Reset) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Overflow <= 1'b0;
      halfFlag <= 1'b0;
      wordCnt  <= '0;
      vldP0    <= 1'b0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
`ifdef HMCAD_PACKER_TESTPAT_EN
      rampCnt  <= '0;
`endif
    end else begin
      Done  <= 1'b0;
      vldP0 <= 1'b0;
      if (Abort) begin
        state    <= IDLE;
        Busy     <= 1'b0;
        halfFlag <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (Start) begin
              wordCnt  <= '0;
              halfFlag <= 1'b0;
              Overflow <= 1'b0;
              if (CaptureLen == 16'd0) begin
                state <= DONE;
                Done  <= 1'b1;
              end else begin
                state <= CAPTURE;
                Busy  <= 1'b1;
              end
            end
          end
          CAPTURE: begin
            if (accept) begin
              halfFlag <= !halfFlag;
              if (halfFlag) begin
                vldP0   <= 1'b1;
                wordCnt <= wordCnt + 16'd1;
              end
            end
            if (vldP0 && (wordCnt == lenLatched)) begin
              state <= DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end

`ifdef HMCAD_PACKER_TESTPAT_EN
      if (startAcc)    rampCnt <= '0;
      else if (accept) rampCnt <= rampCnt + 12'd1;
`endif

      // FIFO pointers and occupancy
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
        level <= '0;
      end else begin
        if (wrEn) wrPtr <= wrPtr + 1'b1;
        if (pop)  rdPtr <= rdPtr + 1'b1;
        if (wrEn && !pop)      level <= level + 1'b1;
        else if (!wrEn && pop) level <= level - 1'b1;
        if (push && !wrEn)     Overflow <= 1'b1;
      end
    end
  end

  // Datapath registers carry no reset; their contents are only observed once qualified.
  always_ff @(posedge DivClk) begin
    if (startAcc)              lenLatched <= CaptureLen;
    if (accept && !halfFlag)   s0Hold     <= sample;
    if (accept && halfFlag)    wordP0     <= {extendSample(sample), extendSample(s0Hold)};
    if (wrEn)                  mem[wrPtr] <= wordP0;
  end

endmodule

// File: tb/tb_hmcad_sample_packer.sv
// Directed bench for hmcad_sample_packer: dutA (ADDR_W=2, zero-extend) and dutB (ADDR_W=9, sign-extend) share stimulus.
module tb_hmcad_sample_packer;
  logic        DivClk;
  logic        Reset;
  logic [15:0] DataVector;
  logic        DataReady;
  logic        Start;
  logic        Abort;
  logic [15:0] CaptureLen;
  logic        OutReady;
`ifdef HMCAD_PACKER_TESTPAT_EN
  logic        TestMode;
`endif

  logic [31:0] OutDataA, OutDataB;
  logic        OutValidA, OutValidB;
  logic        BusyA, BusyB, DoneA, DoneB, OverflowA, OverflowB;
  logic [2:0]  LevelA;
  logic [9:0]  LevelB;

  int nCmp = 0;
  int nBad = 0;

  hmcad_sample_packer #(.ADDR_W(2), .SIGN_EXT(1'b0)) dutA (
    .DivClk(DivClk), .Reset(Reset), .DataVector(DataVector), .DataReady(DataReady),
    .Start(Start), .Abort(Abort), .CaptureLen(CaptureLen),
`ifdef HMCAD_PACKER_TESTPAT_EN
    .TestMode(TestMode),
`endif
    .OutData(OutDataA), .OutValid(OutValidA), .OutReady(OutReady),
    .Busy(BusyA), .Done(DoneA), .Overflow(OverflowA), .Level(LevelA)
  );

  hmcad_sample_packer #(.ADDR_W(9), .SIGN_EXT(1'b1)) dutB (
    .DivClk(DivClk), .Reset(Reset), .DataVector(DataVector), .DataReady(DataReady),
    .Start(Start), .Abort(Abort), .CaptureLen(CaptureLen),
`ifdef HMCAD_PACKER_TESTPAT_EN
    .TestMode(TestMode),
`endif
    .OutData(OutDataB), .OutValid(OutValidB), .OutReady(OutReady),
    .Busy(BusyB), .Done(DoneB), .Overflow(OverflowB), .Level(LevelB)
  );

  initial DivClk = 1'b0;
  always #5 DivClk = ~DivClk;

  task automatic tick();
    @(posedge DivClk);
    #1;
  endtask

  task automatic startCapture(input logic [15:0] len);
    CaptureLen = len;
    Start      = 1'b1;
    tick();
    Start      = 1'b0;
  endtask

  task automatic feed(input logic [11:0] s, input logic [3:0] lsbs);
    DataReady  = 1'b1;
    DataVector = {s, lsbs};
    tick();
    DataReady  = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    nCmp++;
    if ({OutValidA, BusyA, DoneA, OverflowA, LevelA} !== 7'b0) begin
      nBad++;
      $display("FAIL reset_status: got %b want 0000000", {OutValidA, BusyA, DoneA, OverflowA, LevelA});
    end
    nCmp++;
    if (OutDataA !== 32'h0) begin
      nBad++;
      $display("FAIL reset_outdata: got %h want 00000000", OutDataA);
    end
  endtask

  task automatic test_basic();
    bit          pat [12] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
    logic [11:0] smp [8]  = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h135, 12'h246, 12'h357};
    logic [31:0] expW [4] = '{32'h04560123, 32'h0ABC0789, 32'h01350DEF, 32'h03570246};
    logic [31:0] got [$];
    int idx = 0;
    int doneCnt = 0;
    int firstValid = -1;
    logic busyAtDone = 1'b1;
    OutReady = 1'b1;
    startCapture(16'd4);
    nCmp++;
    if (BusyA !== 1'b1) begin
      nBad++;
      $display("FAIL basic_busy_rise: got %b want 1", BusyA);
    end
    for (int i = 0; i < 20; i++) begin
      DataReady  = (i < 12) ? 1'(pat[i]) : 1'b0;
      DataVector = (DataReady && idx < 8) ? {smp[idx], 4'h0} : 16'h0;
      if (DataReady) idx++;
      tick();
      if (OutValidA) begin
        got.push_back(OutDataA);
        if (firstValid < 0) firstValid = i;
      end
      if (DoneA) begin
        doneCnt++;
        busyAtDone = BusyA;
      end
    end
    DataReady = 1'b0;
    nCmp++;
    if (firstValid !== 2) begin
      nBad++;
      $display("FAIL basic_latency: first valid at cycle %0d want 2", firstValid);
    end
    nCmp++;
    if (got.size() !== 4) begin
      nBad++;
      $display("FAIL basic_word_count: got %0d want 4", got.size());
    end
    for (int j = 0; j < 4; j++) begin
      nCmp++;
      if (j >= got.size() || got[j] !== expW[j]) begin
        nBad++;
        $display("FAIL basic_word%0d: got %h want %h", j, (j < got.size()) ? got[j] : 32'hx, expW[j]);
      end
    end
    nCmp++;
    if (doneCnt !== 1 || busyAtDone !== 1'b0) begin
      nBad++;
      $display("FAIL basic_done: pulses %0d busy %b want 1 pulse busy 0", doneCnt, busyAtDone);
    end
  endtask

  task automatic test_signext();
    OutReady = 1'b0;
    startCapture(16'd1);
    feed(12'h800, 4'hF);
    feed(12'h7FF, 4'h5);
    tick();
    nCmp++;
    if (OutDataB !== 32'h07FFF800) begin
      nBad++;
      $display("FAIL signext_word: got %h want 07fff800", OutDataB);
    end
    nCmp++;
    if (OutDataA !== 32'h07FF0800 || DoneA !== 1'b1) begin
      nBad++;
      $display("FAIL zeroext_word: got %h done %b want 07ff0800 done 1", OutDataA, DoneA);
    end
    tick();
  endtask

  task automatic test_overflow();
    int doneCnt = 0;
    logic [31:0] w;
    OutReady = 1'b0;
    startCapture(16'd6);
    for (int i = 0; i < 15; i++) begin
      DataReady  = (i < 12);
      DataVector = {12'(12'h100 + i), 4'h0};
      tick();
      if (DoneA) doneCnt++;
    end
    DataReady = 1'b0;
    nCmp++;
    if ({LevelA, OverflowA} !== {3'd4, 1'b1} || doneCnt !== 1) begin
      nBad++;
      $display("FAIL ovf_status: level %0d ovf %b done %0d want 4 1 1", LevelA, OverflowA, doneCnt);
    end
    OutReady = 1'b1;
    for (int j = 0; j < 4; j++) begin
      w = {4'h0, 12'(12'h100 + 2*j + 1), 4'h0, 12'(12'h100 + 2*j)};
      nCmp++;
      if ({OutValidA, OutDataA} !== {1'b1, w}) begin
        nBad++;
        $display("FAIL ovf_drain%0d: got %b/%h want 1/%h", j, OutValidA, OutDataA, w);
      end
      tick();
    end
    OutReady = 1'b0;
    nCmp++;
    if ({OutValidA, LevelA} !== 4'b0) begin
      nBad++;
      $display("FAIL ovf_empty: got valid %b level %0d want 0 0", OutValidA, LevelA);
    end
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    nCmp++;
    if (OverflowA !== 1'b1) begin
      nBad++;
      $display("FAIL ovf_sticky_abort: got %b want 1", OverflowA);
    end
  endtask

  task automatic test_abort();
    int doneCnt = 0;
    OutReady = 1'b0;
    startCapture(16'd4);
    feed(12'h111, 4'h0);
    feed(12'h222, 4'h0);
    feed(12'h333, 4'h0);
    nCmp++;
    if ({BusyA, LevelA} !== {1'b1, 3'd1}) begin
      nBad++;
      $display("FAIL abort_pre: busy %b level %0d want 1 1", BusyA, LevelA);
    end
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    nCmp++;
    if ({BusyA, OutValidA, LevelA, DoneA} !== 6'b0) begin
      nBad++;
      $display("FAIL abort_flush: busy %b valid %b level %0d done %b want all 0", BusyA, OutValidA, LevelA, DoneA);
    end
    for (int i = 0; i < 4; i++) begin
      DataReady  = 1'b1;
      DataVector = 16'h9990 + 16'(i);
      tick();
      if (DoneA) doneCnt++;
    end
    DataReady = 1'b0;
    nCmp++;
    if (doneCnt !== 0 || LevelA !== 3'd0) begin
      nBad++;
      $display("FAIL abort_idle: done %0d level %0d want 0 0", doneCnt, LevelA);
    end
    startCapture(16'd1);
    feed(12'hAAA, 4'h0);
    feed(12'h555, 4'h0);
    tick();
    nCmp++;
    if ({OutDataA, LevelA, DoneA} !== {32'h05550AAA, 3'd1, 1'b1}) begin
      nBad++;
      $display("FAIL abort_restart: word %h level %0d done %b want 05550aaa 1 1", OutDataA, LevelA, DoneA);
    end
    nCmp++;
    if (OutDataB !== 32'h0555FAAA) begin
      nBad++;
      $display("FAIL abort_restart_sext: got %h want 0555faaa", OutDataB);
    end
    tick();
  endtask

  task automatic test_full_pushpop();
    logic [31:0] w [5];
    for (int j = 0; j < 5; j++) w[j] = {4'h0, 12'(12'h200 + 2*j + 1), 4'h0, 12'(12'h200 + 2*j)};
    OutReady = 1'b0;
    startCapture(16'd5);
    for (int i = 0; i < 10; i++) feed(12'(12'h200 + i), 4'h0);
    nCmp++;
    if ({LevelA, OverflowA} !== {3'd4, 1'b0}) begin
      nBad++;
      $display("FAIL full_level: level %0d ovf %b want 4 0", LevelA, OverflowA);
    end
    OutReady = 1'b1;
    tick();
    nCmp++;
    if ({LevelA, OverflowA, DoneA} !== {3'd4, 1'b0, 1'b1} || OutDataA !== w[1]) begin
      nBad++;
      $display("FAIL full_pushpop: level %0d ovf %b done %b head %h want 4 0 1 %h", LevelA, OverflowA, DoneA, OutDataA, w[1]);
    end
    for (int j = 1; j < 5; j++) begin
      nCmp++;
      if ({OutValidA, OutDataA} !== {1'b1, w[j]}) begin
        nBad++;
        $display("FAIL full_drain%0d: got %b/%h want 1/%h", j, OutValidA, OutDataA, w[j]);
      end
      tick();
    end
    OutReady = 1'b0;
    Start = 1'b1;
    Abort = 1'b1;
    CaptureLen = 16'd4;
    tick();
    Start = 1'b0;
    Abort = 1'b0;
    feed(12'h321, 4'h0);
    feed(12'h654, 4'h0);
    tick();
    nCmp++;
    if ({BusyA, DoneA, LevelA} !== 5'b0) begin
      nBad++;
      $display("FAIL start_abort: busy %b done %b level %0d want 0 0 0", BusyA, DoneA, LevelA);
    end
  endtask

  task automatic test_zero_len();
    startCapture(16'd0);
    nCmp++;
    if ({BusyA, DoneA} !== 2'b01) begin
      nBad++;
      $display("FAIL zero_len: busy %b done %b want 0 1", BusyA, DoneA);
    end
    tick();
    nCmp++;
    if (DoneA !== 1'b0) begin
      nBad++;
      $display("FAIL zero_len_pulse: done %b want 0", DoneA);
    end
  endtask

`ifdef HMCAD_PACKER_TESTPAT_EN
  task automatic test_testpat();
    int nWords = 0;
    int badWords = 0;
    logic [31:0] lastW = 32'h0;
    logic [31:0] expW;
    TestMode = 1'b1;
    OutReady = 1'b1;
    startCapture(16'd2048);
    DataReady  = 1'b1;
    DataVector = 16'hFFFF;
    for (int i = 0; i < 4200; i++) begin
      tick();
      if (OutValidA) begin
        expW = {4'h0, 12'(2*nWords + 1), 4'h0, 12'(2*nWords)};
        if (OutDataA !== expW) badWords++;
        lastW = OutDataA;
        nWords++;
      end
      if (DoneA) break;
    end
    DataReady = 1'b0;
    TestMode  = 1'b0;
    nCmp++;
    if (nWords !== 2048 || badWords !== 0) begin
      nBad++;
      $display("FAIL testpat_ramp: words %0d bad %0d want 2048 0", nWords, badWords);
    end
    nCmp++;
    if (lastW !== 32'h0FFF0FFE) begin
      nBad++;
      $display("FAIL testpat_last: got %h want 0fff0ffe", lastW);
    end
    tick();
  endtask
`endif

  initial begin
    Reset      = 1'b1;
    DataVector = 16'h0;
    DataReady  = 1'b0;
    Start      = 1'b0;
    Abort      = 1'b0;
    CaptureLen = 16'h0;
    OutReady   = 1'b0;
`ifdef HMCAD_PACKER_TESTPAT_EN
    TestMode   = 1'b0;
`endif
    test_reset();
    test_basic();
    test_signext();
    test_overflow();
    test_abort();
    test_full_pushpop();
    test_zero_len();
`ifdef HMCAD_PACKER_TESTPAT_EN
    test_testpat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
